// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   SZ_B/SZ_H/SZ_W/SZ_D : req_size encodings (1, 2, 4, 8 bytes)
//   DMEM_LANES          : byte lanes per dmem word
//   state_t             : LSU control FSM states
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int unsigned DMEM_LANES = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for the LSU.
//   size, off    : access size encoding and byte offset within the dword
//   is_unsigned  : zero-extend (1) or sign-extend (0) the load result
//   wdata        : right-justified store data
//   rbuf         : {high dword, low dword} of raw read data
//   mask         : 16-bit lane mask spanning two consecutive dwords
//   crossing     : access spills into the next dword
//   wshift       : store data shifted onto its lanes across two dwords
//   rdata        : load result, right-justified and extended to 64 bits
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]   size,
    input  logic [2:0]   off,
    input  logic         is_unsigned,
    input  logic [63:0]  wdata,
    input  logic [127:0] rbuf,
    output logic [15:0]  mask,
    output logic         crossing,
    output logic [127:0] wshift,
    output logic [63:0]  rdata
);

    logic [3:0]  nbytes;
    logic [63:0] rshift;

    always_comb begin
        nbytes   = 4'd1 << size;
        mask     = ((16'd1 << nbytes) - 16'd1) << off;
        // off <= 7 and nbytes <= 8, so the 4-bit sum cannot overflow
        crossing = ({1'b0, off} + nbytes) > 4'd8;
        wshift   = {64'd0, wdata} << {off, 3'b000};
        rshift   = 64'(rbuf >> {off, 3'b000});

        case (size)
            SZ_B:    rdata = {{56{~is_unsigned & rshift[7]}},  rshift[7:0]};
            SZ_H:    rdata = {{48{~is_unsigned & rshift[15]}}, rshift[15:0]};
            SZ_W:    rdata = {{32{~is_unsigned & rshift[31]}}, rshift[31:0]};
            default: rdata = rshift;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the pipeline and a 64-bit byte-lane dmem.
//   SPLIT_EN      : 1 = split dword-crossing accesses in two, 0 = reject them
//   clk, rst      : clock, asynchronous active-high reset
//   req_*         : pipeline request (valid/ready handshake)
//   resp_*        : response with extended load data and crossing error
//   we_dmem, dmem_word_sel, r_dmem_addr, w_dmem_data : dmem drive
//   dmem_data     : combinational dmem read data for r_dmem_addr
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        we_dmem,
    output logic [7:0]  dmem_word_sel,
    output logic [63:0] r_dmem_addr,
    output logic [63:0] w_dmem_data,
    input  logic [63:0] dmem_data
);

    localparam logic SPLIT = (SPLIT_EN != 0);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] lo_buf;
    logic [63:0] hi_buf;

    logic [1:0]   a_size;
    logic [2:0]   a_off;
    logic [63:0]  a_wdata;
    logic [127:0] a_rbuf;
    logic [15:0]  mask;
    logic         crossing;
    logic [127:0] wshift;
    logic [63:0]  load_data;

    // Outputs are registered, so the ACC0 drive is computed from the live
    // request in IDLE; later states use the latched copy. Read data for the
    // final beat comes straight from dmem_data so the response can be
    // registered on the same edge that would otherwise fill the buffer.
    always_comb begin
        if (state == IDLE) begin
            a_size  = req_size;
            a_off   = req_addr[2:0];
            a_wdata = req_wdata;
        end else begin
            a_size  = size_q;
            a_off   = addr_q[2:0];
            a_wdata = wdata_q;
        end
        a_rbuf = (state == ACC1) ? {dmem_data, lo_buf} : {hi_buf, dmem_data};
    end

    lsu_align u_align (
        .size        (a_size),
        .off         (a_off),
        .is_unsigned (uns_q),
        .wdata       (a_wdata),
        .rbuf        (a_rbuf),
        .mask        (mask),
        .crossing    (crossing),
        .wshift      (wshift),
        .rdata       (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            we_q          <= 1'b0;
            size_q        <= SZ_B;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lo_buf        <= '0;
            hi_buf        <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            we_dmem       <= 1'b0;
            dmem_word_sel <= '0;
            r_dmem_addr   <= '0;
            w_dmem_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ACC0;
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        lo_buf    <= '0;
                        hi_buf    <= '0;
                        // A rejected crossing access never touches dmem
                        if (!(crossing && !SPLIT)) begin
                            we_dmem       <= req_we;
                            dmem_word_sel <= mask[7:0];
                            r_dmem_addr   <= {req_addr[63:3], 3'b000};
                            w_dmem_data   <= wshift[63:0];
                        end
                    end
                end
                ACC0: begin
                    lo_buf <= dmem_data;
                    if (crossing && SPLIT) begin
                        state         <= ACC1;
                        we_dmem       <= we_q;
                        dmem_word_sel <= mask[15:8];
                        r_dmem_addr   <= {addr_q[63:3], 3'b000} + 64'd8;
                        w_dmem_data   <= wshift[127:64];
                    end else begin
                        state         <= RESP;
                        we_dmem       <= 1'b0;
                        dmem_word_sel <= '0;
                        r_dmem_addr   <= '0;
                        w_dmem_data   <= '0;
                        resp_valid    <= 1'b1;
                        // Only reachable with crossing set when splitting is off
                        resp_err      <= crossing;
                        resp_rdata    <= (we_q || crossing) ? '0 : load_data;
                    end
                end
                ACC1: begin
                    hi_buf        <= dmem_data;
                    state         <= RESP;
                    we_dmem       <= 1'b0;
                    dmem_word_sel <= '0;
                    r_dmem_addr   <= '0;
                    w_dmem_data   <= '0;
                    resp_valid    <= 1'b1;
                    resp_err      <= 1'b0;
                    resp_rdata    <= we_q ? '0 : load_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
//   dut  : SPLIT_EN=1 with a 256-dword byte-lane memory model
//   dut0 : SPLIT_EN=0 with read data tied to zero
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_err, we_dmem;
    logic [63:0] resp_rdata, r_dmem_addr, w_dmem_data, dmem_data;
    logic [7:0]  dmem_word_sel;

    logic        req_ready0, resp_valid0, resp_err0, we_dmem0;
    logic [63:0] resp_rdata0, r_dmem_addr0, w_dmem_data0;
    logic [63:0] dmem_data0 = '0;
    logic [7:0]  dmem_word_sel0;

    logic [63:0] mem [0:255];
    int          wr_cnt = 0;
    int          wr_cnt0 = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    lsu #(.SPLIT_EN(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .we_dmem(we_dmem), .dmem_word_sel(dmem_word_sel), .r_dmem_addr(r_dmem_addr),
        .w_dmem_data(w_dmem_data), .dmem_data(dmem_data)
    );

    lsu #(.SPLIT_EN(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .we_dmem(we_dmem0), .dmem_word_sel(dmem_word_sel0), .r_dmem_addr(r_dmem_addr0),
        .w_dmem_data(w_dmem_data0), .dmem_data(dmem_data0)
    );

    assign dmem_data = mem[r_dmem_addr[10:3]];

    always @(posedge clk) begin
        if (we_dmem === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            for (int i = 0; i < 8; i++)
                if (dmem_word_sel[i]) mem[r_dmem_addr[10:3]][8*i +: 8] <= w_dmem_data[8*i +: 8];
        end
        if (we_dmem0 === 1'b1) wr_cnt0 <= wr_cnt0 + 1;
    end

    // Waits for ready, presents one request for one accepted edge, returns at
    // the negedge inside ACC0.
    task automatic issue(input bit to0, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [63:0] a, input logic [63:0] wd);
        int n = 0;
        while (((to0 ? req_ready0 : req_ready) !== 1'b1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n == 10) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: req_ready never 1 within 10 cycles");
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        if (to0) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_valid0 = 1'b0;
    endtask

    // Counts negedges after the accept edge until resp_valid; -1 on timeout.
    task automatic wait_resp(input bit to0, input int start, output int lat);
        lat = start;
        while (((to0 ? resp_valid0 : resp_valid) !== 1'b1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if ((to0 ? resp_valid0 : resp_valid) !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0h want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0h want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %0h want 0", resp_err); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL rst_resp_rdata: got %0h want 0", resp_rdata); end
        checks++; if (we_dmem !== 1'b0) begin errors++; $display("FAIL rst_we: got %0h want 0", we_dmem); end
        checks++; if (dmem_word_sel !== 8'h0) begin errors++; $display("FAIL rst_sel: got %0h want 0", dmem_word_sel); end
        checks++; if (r_dmem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %0h want 0", r_dmem_addr); end
        checks++; if (w_dmem_data !== 64'h0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", w_dmem_data); end
        checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL rst_req_ready0: got %0h want 1", req_ready0); end
        rst = 1'b0;
    endtask

    task automatic test_dword;
        int lat;
        int w0;
        w0 = wr_cnt;
        issue(0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
        checks++; if (we_dmem !== 1'b1) begin errors++; $display("FAIL dw_st_we: got %0h want 1", we_dmem); end
        checks++; if (dmem_word_sel !== 8'hFF) begin errors++; $display("FAIL dw_st_sel: got %0h want ff", dmem_word_sel); end
        checks++; if (r_dmem_addr !== 64'h10) begin errors++; $display("FAIL dw_st_addr: got %0h want 10", r_dmem_addr); end
        checks++; if (w_dmem_data !== 64'h1122334455667788) begin errors++; $display("FAIL dw_st_wdata: got %0h want 1122334455667788", w_dmem_data); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL dw_acc0_ready: got %0h want 0", req_ready); end
        wait_resp(0, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dw_st_lat: got %0d want 2", lat); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL dw_st_rdata: got %0h want 0", resp_rdata); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL dw_st_writes: got %0d want 1", wr_cnt - w0); end
        issue(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        checks++; if (we_dmem !== 1'b0) begin errors++; $display("FAIL dw_ld_we: got %0h want 0", we_dmem); end
        checks++; if (dmem_word_sel !== 8'hFF) begin errors++; $display("FAIL dw_ld_sel: got %0h want ff", dmem_word_sel); end
        wait_resp(0, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dw_ld_lat: got %0d want 2", lat); end
        checks++; if (resp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL dw_ld_rdata: got %0h want 1122334455667788", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL dw_ld_err: got %0h want 0", resp_err); end
    endtask

    task automatic test_byte;
        int lat;
        issue(0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h80);
        checks++; if (dmem_word_sel !== 8'h08) begin errors++; $display("FAIL b_st_sel: got %0h want 08", dmem_word_sel); end
        checks++; if (w_dmem_data !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL b_st_wdata: got %0h want 80000000", w_dmem_data); end
        wait_resp(0, 1, lat);
        issue(0, 1'b0, 2'd0, 1'b0, 64'h13, 64'h0);
        wait_resp(0, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b_ld_lat: got %0d want 2", lat); end
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL b_ld_signed: got %0h want ffffffffffffff80", resp_rdata); end
        issue(0, 1'b0, 2'd0, 1'b1, 64'h13, 64'h0);
        wait_resp(0, 1, lat);
        checks++; if (resp_rdata !== 64'h80) begin errors++; $display("FAIL b_ld_unsigned: got %0h want 80", resp_rdata); end
    endtask

    task automatic test_split;
        int lat;
        int w0;
        w0 = wr_cnt;
        issue(0, 1'b1, 2'd2, 1'b0, 64'h1E, 64'hAABBCCDD);
        checks++; if (r_dmem_addr !== 64'h18) begin errors++; $display("FAIL sp_acc0_addr: got %0h want 18", r_dmem_addr); end
        checks++; if (dmem_word_sel !== 8'hC0) begin errors++; $display("FAIL sp_acc0_sel: got %0h want c0", dmem_word_sel); end
        checks++; if (w_dmem_data !== 64'hCCDD_0000_0000_0000) begin errors++; $display("FAIL sp_acc0_wdata: got %0h want ccdd000000000000", w_dmem_data); end
        @(negedge clk);
        checks++; if (r_dmem_addr !== 64'h20) begin errors++; $display("FAIL sp_acc1_addr: got %0h want 20", r_dmem_addr); end
        checks++; if (dmem_word_sel !== 8'h03) begin errors++; $display("FAIL sp_acc1_sel: got %0h want 03", dmem_word_sel); end
        checks++; if (w_dmem_data !== 64'hAABB) begin errors++; $display("FAIL sp_acc1_wdata: got %0h want aabb", w_dmem_data); end
        checks++; if (we_dmem !== 1'b1) begin errors++; $display("FAIL sp_acc1_we: got %0h want 1", we_dmem); end
        wait_resp(0, 2, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sp_st_lat: got %0d want 3", lat); end
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL sp_st_writes: got %0d want 2", wr_cnt - w0); end
        issue(0, 1'b0, 2'd2, 1'b0, 64'h1E, 64'h0);
        @(negedge clk);
        wait_resp(0, 2, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sp_ld_lat: got %0d want 3", lat); end
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_AABB_CCDD) begin errors++; $display("FAIL sp_ld_rdata: got %0h want ffffffffaabbccdd", resp_rdata); end
    endtask

    task automatic test_wrap;
        int lat;
        issue(0, 1'b1, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h12345678);
        checks++; if (r_dmem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wr_acc0_addr: got %0h want fffffffffffffff8", r_dmem_addr); end
        @(negedge clk);
        checks++; if (r_dmem_addr !== 64'h0) begin errors++; $display("FAIL wr_acc1_addr: got %0h want 0", r_dmem_addr); end
        checks++; if (dmem_word_sel !== 8'h03) begin errors++; $display("FAIL wr_acc1_sel: got %0h want 03", dmem_word_sel); end
        wait_resp(0, 2, lat);
        issue(0, 1'b0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        @(negedge clk);
        wait_resp(0, 2, lat);
        checks++; if (resp_rdata !== 64'h12345678) begin errors++; $display("FAIL wr_ld_rdata: got %0h want 12345678", resp_rdata); end
    endtask

    task automatic test_no_split;
        int lat;
        int w0;
        w0 = wr_cnt0;
        issue(1, 1'b1, 2'd1, 1'b0, 64'h0F, 64'h1234);
        checks++; if (we_dmem0 !== 1'b0) begin errors++; $display("FAIL ns_we: got %0h want 0", we_dmem0); end
        checks++; if (dmem_word_sel0 !== 8'h0) begin errors++; $display("FAIL ns_sel: got %0h want 0", dmem_word_sel0); end
        wait_resp(1, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ns_lat: got %0d want 2", lat); end
        checks++; if (resp_err0 !== 1'b1) begin errors++; $display("FAIL ns_err: got %0h want 1", resp_err0); end
        checks++; if (resp_rdata0 !== 64'h0) begin errors++; $display("FAIL ns_rdata: got %0h want 0", resp_rdata0); end
        checks++; if (wr_cnt0 - w0 !== 0) begin errors++; $display("FAIL ns_writes: got %0d want 0", wr_cnt0 - w0); end
        issue(1, 1'b0, 2'd1, 1'b0, 64'h0E, 64'h0);
        wait_resp(1, 1, lat);
        checks++; if (resp_err0 !== 1'b0) begin errors++; $display("FAIL ns_aligned_err: got %0h want 0", resp_err0); end
    endtask

    task automatic test_backpressure;
        int lat;
        resp_ready = 1'b0;
        issue(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        wait_resp(0, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bp_lat: got %0d want 2", lat); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0h want 1", i, resp_valid); end
            checks++; if (resp_rdata !== 64'h1122_3344_8066_7788) begin errors++; $display("FAIL bp_rdata[%0d]: got %0h want 1122334480667788", i, resp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0h want 0", i, req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0h want 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0h want 1", req_ready); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int w0;
        w0 = wr_cnt;
        issue(0, 1'b1, 2'd2, 1'b0, 64'h1E, 64'h01020304);
        @(negedge clk);
        checks++; if (we_dmem !== 1'b1) begin errors++; $display("FAIL rm_acc1_we: got %0h want 1", we_dmem); end
        rst = 1'b1;
        #1;
        checks++; if (we_dmem !== 1'b0) begin errors++; $display("FAIL rm_async_we: got %0h want 0", we_dmem); end
        checks++; if (dmem_word_sel !== 8'h0) begin errors++; $display("FAIL rm_async_sel: got %0h want 0", dmem_word_sel); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_resp_valid: got %0h want 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_req_ready: got %0h want 1", req_ready); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL rm_writes: got %0d want 1", wr_cnt - w0); end
        rst = 1'b0;
        issue(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        wait_resp(0, 1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rm_ld_lat: got %0d want 2", lat); end
        checks++; if (resp_rdata !== 64'h1122_3344_8066_7788) begin errors++; $display("FAIL rm_ld_rdata: got %0h want 1122334480667788", resp_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;

        test_reset;
        test_dword;
        test_byte;
        test_split;
        test_wrap;
        test_no_split;
        test_backpressure;
        test_reset_mid;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter SPLIT_EN, default 1: 1 = split dword-crossing accesses into two dmem accesses; 0 = reject them with resp_err.
REQ-002 clk  in  1  sole clock; all state changes on posedge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 req_valid  in  1  pipeline request present.
REQ-005 req_ready  out  1  LSU can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-008 req_unsigned  in  1  zero-extend the load result when 1; sign-extend when 0.
REQ-009 req_addr  in  64  byte address, any alignment.
REQ-010 req_wdata  in  64  store data, right-justified.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  pipeline accepts the response.
REQ-013 resp_rdata  out  64  extended load data; 0 for stores.
REQ-014 resp_err  out  1  crossing access rejected (SPLIT_EN=0 only).
REQ-015 we_dmem  out  1  dmem write enable.
REQ-016 dmem_word_sel  out  8  dmem byte-lane enables; bit i selects bits [8i+7:8i].
REQ-017 r_dmem_addr  out  64  dmem address; bits [2:0] are always 0.
REQ-018 w_dmem_data  out  64  dmem write data, lane-aligned.
REQ-019 dmem_data  in  64  combinational dmem read data for r_dmem_addr.

Function
REQ-020 FSM states: IDLE, ACC0, ACC1, RESP.
REQ-021 IDLE: req_ready=1; on req_valid, latch all req_* fields and go to ACC0.
REQ-022 ACC0 and ACC1: req_ready=0.
REQ-023 RESP: req_ready=0.
REQ-024 Derived values: off=addr[2:0]; nbytes=1<<size; 16-bit mask=((1<<nbytes)-1)<<off; crossing=(off+nbytes>8).
REQ-025 ACC0 dmem drive: r_dmem_addr={addr[63:3],3'b000}; dmem_word_sel=mask[7:0]; w_dmem_data=low 64 bits of ({64'b0,wdata}<<(8*off)); we_dmem=req_we.
REQ-026 ACC0 load capture: latch dmem_data into lo_buf at the end of ACC0.
REQ-027 ACC0 exit: go to ACC1 if crossing and SPLIT_EN=1; otherwise go to RESP.
REQ-028 ACC1 dmem drive: r_dmem_addr=({addr[63:3],3'b000}+8) mod 2^64; dmem_word_sel=mask[15:8]; w_dmem_data=high 64 bits of the shifted store data; we_dmem=req_we.
REQ-029 ACC1 load capture: latch dmem_data into hi_buf; then go to RESP.
REQ-030 Crossing with SPLIT_EN=0: no dmem access (we_dmem=0, dmem_word_sel=0 in ACC0); go to RESP with resp_err=1 and resp_rdata=0.
REQ-031 Load result: low (8*nbytes) bits of ({hi_buf,lo_buf}>>(8*off)), extended to 64 bits per req_unsigned; size 3 ignores req_unsigned.
REQ-032 RESP: resp_valid=1 and resp_rdata/resp_err stable until resp_ready=1; go to IDLE on the cycle resp_ready=1.
REQ-033 Latency, accept at cycle N: resp_valid at N+2 for a non-crossing access, N+3 for a crossing access.
REQ-034 Throughput: at most one request per 3 cycles; no request accepted while in RESP.
REQ-035 Outside ACC0/ACC1: we_dmem=0, dmem_word_sel=0, r_dmem_addr=0, w_dmem_data=0.
REQ-036 Outside RESP: resp_valid=0, resp_err=0, resp_rdata=0.
REQ-037 Address wrap: addr=0xFFFF_FFFF_FFFF_FFFE with size 2 gives ACC1 address 0x0.

Reset
REQ-038 Reset asserted: state=IDLE; req_ready=1; all other outputs 0; buffers cleared.
REQ-039 Reset asserted during ACC0/ACC1: we_dmem drops immediately (asynchronously); an ACC0 write already clocked into dmem is not rolled back; no response is produced.
REQ-040 Reset deassertion: the first request is accepted on the first posedge with rst=0.

Structure
REQ-041 Shared package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), FSM state enum, DMEM_LANES=8.
REQ-042 Sub-module lsu_align (combinational): mask generation, store shift, load shift/extend; FSM, handshakes and buffers stay in lsu.

Verification
REQ-043 Store dword 0x1122334455667788 @0x10, then load dword @0x10 -> one write, word_sel=0xFF, r_dmem_addr=0x10; rdata=0x1122334455667788, resp at N+2.
REQ-044 Store byte 0x80 @0x13, load byte signed @0x13 -> word_sel=0x08, w_dmem_data[31:24]=0x80; rdata=0xFFFF_FFFF_FFFF_FF80; same load unsigned -> rdata=0x80.
REQ-045 SPLIT_EN=1: store word 0xAABBCCDD @0x1E -> ACC0 addr 0x18, sel=0xC0; ACC1 addr 0x20, sel=0x03; load word signed @0x1E -> 0xFFFF_FFFF_AABB_CCDD at N+3.
REQ-046 SPLIT_EN=0: store half @0x0F -> no we_dmem pulse, resp_err=1.
REQ-047 Hold resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-048 Assert rst during ACC1 of a crossing store -> we_dmem=0 the same cycle, no resp_valid, req_ready=1; the next aligned load completes normally.
